// File: rtl/name_table_scroll_ram_pkg.sv
// Shared definitions for the scrolling name table.
//   NT_W_DEF / NT_H_DEF / NT_PAGES_DEF : default table geometry
//   BYTE / LANES                       : tile index width and tiles per RAM word
//   fill_state_e                       : fill engine states (only used when
//                                        NAMETABLE_CLEAR_EN is defined)
package name_table_scroll_ram_pkg;

  localparam int NT_W_DEF     = 32;
  localparam int NT_H_DEF     = 30;
  localparam int NT_PAGES_DEF = 2;
  localparam int BYTE         = 8;
  localparam int LANES        = 4;

  typedef enum logic {
    FILL_IDLE  = 1'b0,
    FILL_CLEAR = 1'b1
  } fill_state_e;

endpackage

// File: rtl/nt_bram_dp.sv
// True dual-port block RAM holding the packed name table.
// Ports:
//   clk_i, rst_i         clock, async active-high reset (read registers only)
//   a_en_i               port A read enable
//   a_we_i               port A byte write enables (lane k = bits [8k+7:8k])
//   a_addr_i, a_wdata_i  port A word address / write data
//   a_rdata_o            port A registered read data, read-first
//   b_en_i, b_addr_i     port B read enable / word address
//   b_rdata_o            port B registered read data
module nt_bram_dp
  import name_table_scroll_ram_pkg::*;
#(
  parameter int DEPTH     = 480,
  parameter int ADDR_W    = 9,
  parameter     INIT_FILE = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    a_en_i,
  input  logic [LANES-1:0]        a_we_i,
  input  logic [ADDR_W-1:0]       a_addr_i,
  input  logic [LANES*BYTE-1:0]   a_wdata_i,
  output logic [LANES*BYTE-1:0]   a_rdata_o,
  input  logic                    b_en_i,
  input  logic [ADDR_W-1:0]       b_addr_i,
  output logic [LANES*BYTE-1:0]   b_rdata_o
);

  logic [LANES*BYTE-1:0] mem [DEPTH];
  logic [LANES*BYTE-1:0] a_rdata_q;
  logic [LANES*BYTE-1:0] b_rdata_q;

  // The array itself is never reset; its contents survive rst.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (a_we_i[k]) mem[a_addr_i][k*BYTE +: BYTE] <= a_wdata_i[k*BYTE +: BYTE];
    end
  end

  // Nonblocking update of mem means both reads see the pre-write word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem[a_addr_i];
      if (b_en_i) b_rdata_q <= mem[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/name_table_scroll_ram.sv
// Multi-page background name table with hardware scroll.
// Tiles are 8-bit indices packed 4 per 32-bit word; pages sit side by side in X.
// Ports:
//   clk_i, rst_i                          clock, async active-high reset
//   cpu_addr_i/cpu_wdata_i/cpu_we_i/
//   cpu_re_i/cpu_ready_o/cpu_rdata_o/
//   cpu_rvalid_o                          CPU word access, 1-cycle read latency
//   frame_start_i, scroll_x_i, scroll_y_i shadow scroll, applied at frame start
//   ppu_req_i, ppu_col_i, ppu_row_i,
//   ppu_valid_o, ppu_tile_o               3-stage pipelined tile fetch
//   clear_start_i, clear_value_i,
//   clear_busy_o, clear_done_o            table fill engine
// Build option: NAMETABLE_CLEAR_EN enables the fill engine; otherwise the
// clear inputs are ignored, clear_busy_o/clear_done_o are 0 and cpu_ready_o is 1.
module name_table_scroll_ram
  import name_table_scroll_ram_pkg::*;
#(
  parameter int NT_W      = NT_W_DEF,
  parameter int NT_H      = NT_H_DEF,
  parameter int NT_PAGES  = NT_PAGES_DEF,
  parameter     INIT_FILE = "",
  localparam int DEPTH    = NT_PAGES*NT_W*NT_H/LANES,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int SX_W     = $clog2(NT_W*NT_PAGES),
  localparam int SY_W     = $clog2(NT_H),
  localparam int COL_W    = $clog2(NT_W),
  localparam int ROW_W    = $clog2(NT_H)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_we_i,
  input  logic              cpu_re_i,
  output logic              cpu_ready_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_rvalid_o,
  input  logic              frame_start_i,
  input  logic [SX_W-1:0]   scroll_x_i,
  input  logic [SY_W-1:0]   scroll_y_i,
  input  logic              ppu_req_i,
  input  logic [COL_W-1:0]  ppu_col_i,
  input  logic [ROW_W-1:0]  ppu_row_i,
  output logic              ppu_valid_o,
  output logic [7:0]        ppu_tile_o,
  input  logic              clear_start_i,
  input  logic [7:0]        clear_value_i,
  output logic              clear_busy_o,
  output logic              clear_done_o
);

  localparam int XSPAN      = NT_W*NT_PAGES;
  localparam int PAGE_TILES = NT_W*NT_H;
  localparam int IDX_W      = ADDR_W + 2;

  // ---------------- port A (CPU / fill) ----------------
  logic              fill_busy;
  logic              cpu_accept;
  logic              a_en;
  logic [3:0]        a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [31:0]       a_rdata;
  logic              cpu_rvalid_q;

  assign cpu_ready_o = !fill_busy;
  assign cpu_accept  = cpu_ready_o && (|cpu_we_i || cpu_re_i);
  assign a_en        = cpu_accept && cpu_re_i;

`ifdef NAMETABLE_CLEAR_EN
  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [7:0]        fill_val_q, fill_val_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL_IDLE;
      fill_addr_q <= '0;
      fill_val_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_val_q  <= fill_val_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_val_d  = fill_val_q;
    done_d      = 1'b0;
    unique case (state_q)
      FILL_IDLE: begin
        if (clear_start_i) begin
          state_d     = FILL_CLEAR;
          fill_addr_d = '0;
          fill_val_d  = clear_value_i;
        end
      end
      FILL_CLEAR: begin
        fill_addr_d = fill_addr_q + ADDR_W'(1);
        if (fill_addr_q == ADDR_W'(DEPTH-1)) begin
          state_d = FILL_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  assign fill_busy    = (state_q == FILL_CLEAR);
  assign clear_busy_o = fill_busy;
  assign clear_done_o = done_q;

  always_comb begin
    a_we    = cpu_accept ? cpu_we_i : 4'h0;
    a_addr  = cpu_addr_i;
    a_wdata = cpu_wdata_i;
    if (fill_busy) begin
      a_we    = 4'hF;
      a_addr  = fill_addr_q;
      a_wdata = {LANES{fill_val_q}};
    end
  end
`else
  logic unused_clear;
  assign unused_clear = ^{clear_start_i, clear_value_i};
  assign fill_busy    = 1'b0;
  assign clear_busy_o = 1'b0;
  assign clear_done_o = 1'b0;
  assign a_we         = cpu_accept ? cpu_we_i : 4'h0;
  assign a_addr       = cpu_addr_i;
  assign a_wdata      = cpu_wdata_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cpu_rvalid_q <= 1'b0;
    else       cpu_rvalid_q <= a_en;
  end

  assign cpu_rvalid_o = cpu_rvalid_q;
  assign cpu_rdata_o  = a_rdata;

  // ---------------- scroll registers ----------------
  logic [SX_W-1:0] sx_act_q;
  logic [SY_W-1:0] sy_act_q;
  logic [SY_W-1:0] sy_load;

  // An out-of-range Y scroll would break the single-subtract wrap below.
  assign sy_load = (int'(scroll_y_i) >= NT_H) ? '0 : scroll_y_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sx_act_q <= '0;
      sy_act_q <= '0;
    end else if (frame_start_i) begin
      sx_act_q <= scroll_x_i;
      sy_act_q <= sy_load;
    end
  end

  // ---------------- PPU pipeline ----------------
  int               x_sum, y_sum, idx_sum;
  logic [IDX_W-1:0] s1_idx_d;
  logic             s1_oob_d;

  always_comb begin
    x_sum = int'(sx_act_q) + int'(ppu_col_i);
    if (x_sum >= XSPAN) x_sum = x_sum - XSPAN;
    y_sum = int'(sy_act_q) + int'(ppu_row_i);
    if (y_sum >= NT_H) y_sum = y_sum - NT_H;
    idx_sum  = (x_sum / NT_W) * PAGE_TILES + y_sum * NT_W + (x_sum % NT_W);
    s1_idx_d = IDX_W'(idx_sum);
    s1_oob_d = (int'(ppu_row_i) >= NT_H);
  end

  logic              s1_valid_q, s1_oob_q;
  logic [ADDR_W-1:0] s1_word_q;
  logic [1:0]        s1_lane_q;
  logic              s2_valid_q, s2_oob_q;
  logic [1:0]        s2_lane_q;
  logic              ppu_valid_q;
  logic [7:0]        ppu_tile_q;
  logic [31:0]       b_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_oob_q    <= 1'b0;
      s1_word_q   <= '0;
      s1_lane_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_oob_q    <= 1'b0;
      s2_lane_q   <= '0;
      ppu_valid_q <= 1'b0;
      ppu_tile_q  <= '0;
    end else begin
      s1_valid_q  <= ppu_req_i;
      s1_oob_q    <= s1_oob_d;
      s1_word_q   <= s1_idx_d[IDX_W-1:2];
      s1_lane_q   <= s1_idx_d[1:0];
      s2_valid_q  <= s1_valid_q;
      s2_oob_q    <= s1_oob_q;
      s2_lane_q   <= s1_lane_q;
      ppu_valid_q <= s2_valid_q;
      if (s2_valid_q) ppu_tile_q <= s2_oob_q ? 8'h00 : b_rdata[s2_lane_q*BYTE +: BYTE];
    end
  end

  assign ppu_valid_o = ppu_valid_q;
  assign ppu_tile_o  = ppu_tile_q;

  nt_bram_dp #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_en_i    (a_en),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (a_rdata),
    .b_en_i    (s1_valid_q),
    .b_addr_i  (s1_word_q),
    .b_rdata_o (b_rdata)
  );

endmodule

// File: tb/tb_name_table_scroll_ram.sv
module tb_name_table_scroll_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_we;
  logic        cpu_re;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        frame_start;
  logic [5:0]  scroll_x;
  logic [4:0]  scroll_y;
  logic        ppu_req;
  logic [4:0]  ppu_col;
  logic [4:0]  ppu_row;
  logic        ppu_valid;
  logic [7:0]  ppu_tile;
  logic        clear_start;
  logic [7:0]  clear_value;
  logic        clear_busy;
  logic        clear_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  name_table_scroll_ram dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_we_i      (cpu_we),
    .cpu_re_i      (cpu_re),
    .cpu_ready_o   (cpu_ready),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_rvalid_o  (cpu_rvalid),
    .frame_start_i (frame_start),
    .scroll_x_i    (scroll_x),
    .scroll_y_i    (scroll_y),
    .ppu_req_i     (ppu_req),
    .ppu_col_i     (ppu_col),
    .ppu_row_i     (ppu_row),
    .ppu_valid_o   (ppu_valid),
    .ppu_tile_o    (ppu_tile),
    .clear_start_i (clear_start),
    .clear_value_i (clear_value),
    .clear_busy_o  (clear_busy),
    .clear_done_o  (clear_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] we);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = we;
    tick();
    cpu_we    = 4'h0;
  endtask

  task automatic cpu_read(input logic [8:0] a, output logic [31:0] d, output logic v);
    cpu_addr = a;
    cpu_re   = 1'b1;
    tick();
    cpu_re   = 1'b0;
    d        = cpu_rdata;
    v        = cpu_rvalid;
  endtask

  task automatic fetch(input string tag, input logic [4:0] col, input logic [4:0] row,
                       input logic [7:0] exp);
    ppu_col = col;
    ppu_row = row;
    ppu_req = 1'b1;
    tick();
    ppu_req = 1'b0;
    tick();
    tick();
    chk({tag, "_valid"}, {31'd0, ppu_valid}, 32'd1);
    chk(tag, {24'd0, ppu_tile}, {24'd0, exp});
  endtask

  initial begin
    logic [31:0] rd;
    logic        rv;
    logic [7:0]  exp_tiles [4];
    int          bad;

    rst = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = '0; cpu_re = 1'b0;
    frame_start = 1'b0; scroll_x = '0; scroll_y = '0;
    ppu_req = 1'b0; ppu_col = '0; ppu_row = '0;
    clear_start = 1'b0; clear_value = '0;
    tick();
    tick();
    chk("rst_rdata",  cpu_rdata, 32'h0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_tile",   {24'd0, ppu_tile}, 32'd0);
    chk("rst_pvalid", {31'd0, ppu_valid}, 32'd0);
    chk("rst_busy",   {31'd0, clear_busy}, 32'd0);
    chk("rst_done",   {31'd0, clear_done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_idle", {31'd0, cpu_ready}, 32'd1);

    // byte-enable writes then read
    cpu_write(9'd0, 32'h44332211, 4'hF);
    cpu_write(9'd0, 32'hAABBCCDD, 4'h5);
    cpu_read(9'd0, rd, rv);
    chk("rd_valid", {31'd0, rv}, 32'd1);
    chk("rd_bytes", rd, 32'h44BB22DD);
    tick();
    chk("rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);

    // same-cycle write+read: old data returned
    cpu_addr = 9'd0; cpu_wdata = 32'h12345678; cpu_we = 4'hF; cpu_re = 1'b1;
    tick();
    cpu_we = 4'h0; cpu_re = 1'b0;
    chk("rd_first_old", cpu_rdata, 32'h44BB22DD);
    cpu_read(9'd0, rd, rv);
    chk("rd_first_new", rd, 32'h12345678);

    // PPU fetch latency and throughput
    cpu_write(9'd1, 32'h04030201, 4'hF);
    cpu_write(9'd1, 32'h00007E00, 4'h2);
    ppu_col = 5'd5; ppu_row = 5'd0; ppu_req = 1'b1;
    tick();
    ppu_req = 1'b0;
    chk("lat_c1", {31'd0, ppu_valid}, 32'd0);
    tick();
    chk("lat_c2", {31'd0, ppu_valid}, 32'd0);
    tick();
    chk("lat_c3_valid", {31'd0, ppu_valid}, 32'd1);
    chk("lat_c3_tile", {24'd0, ppu_tile}, 32'h7E);
    tick();
    chk("hold_valid", {31'd0, ppu_valid}, 32'd0);
    chk("hold_tile", {24'd0, ppu_tile}, 32'h7E);

    exp_tiles[0] = 8'h01; exp_tiles[1] = 8'h7E; exp_tiles[2] = 8'h03; exp_tiles[3] = 8'h04;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        ppu_req = 1'b1;
        ppu_col = 5'(4 + i);
      end else begin
        ppu_req = 1'b0;
      end
      tick();
      if (i >= 2 && i < 6) begin
        chk("b2b_valid", {31'd0, ppu_valid}, 32'd1);
        chk("b2b_tile", {24'd0, ppu_tile}, {24'd0, exp_tiles[i-2]});
      end
      if (i == 6) chk("b2b_end", {31'd0, ppu_valid}, 32'd0);
    end

    // horizontal scroll and wrap
    cpu_write(9'd2, 32'h0C0B0A09, 4'hF);
    scroll_x = 6'd60;
    fetch("sx_shadow", 5'd9, 5'd0, 8'h0A);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fetch("sx_wrap", 5'd9, 5'd0, 8'h7E);

    // vertical scroll, wrap, clamp and out-of-range row
    cpu_write(9'd8, 32'h0000005A, 4'h1);
    scroll_x = 6'd0; scroll_y = 5'd29;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fetch("sy_wrap", 5'd0, 5'd2, 8'h5A);
    fetch("row_oob", 5'd0, 5'd31, 8'h00);
    scroll_y = 5'd31;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fetch("sy_clamp", 5'd0, 5'd0, 8'h78);
    scroll_y = 5'd5;
    fetch("sy_midframe", 5'd0, 5'd0, 8'h78);
    scroll_y = 5'd0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;

    // CPU write colliding with PPU read of the same word
    ppu_col = 5'd0; ppu_row = 5'd1; ppu_req = 1'b1;
    tick();
    ppu_req = 1'b0;
    cpu_addr = 9'd8; cpu_wdata = 32'h000000A5; cpu_we = 4'h1;
    tick();
    cpu_we = 4'h0;
    tick();
    chk("collide_old", {24'd0, ppu_tile}, 32'h5A);
    fetch("collide_new", 5'd0, 5'd1, 8'hA5);

`ifdef NAMETABLE_CLEAR_EN
    begin
      int busy_cnt;
      int done_cnt;
      int done_idx;
      busy_cnt = 0; done_cnt = 0; done_idx = -1;
      clear_value = 8'hFF;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      clear_value = 8'h00;
      for (int i = 0; i < 500; i++) begin
        if (clear_busy) busy_cnt++;
        if (clear_done) begin
          done_cnt++;
          done_idx = i;
        end
        if (i == 10) begin
          chk("fill_ready_low", {31'd0, cpu_ready}, 32'd0);
          cpu_addr = 9'd3; cpu_wdata = 32'h11111111; cpu_we = 4'hF;
          clear_start = 1'b1;
        end else begin
          cpu_we = 4'h0;
          clear_start = 1'b0;
        end
        tick();
      end
      chk("fill_busy_cycles", busy_cnt, 32'd480);
      chk("fill_done_count", done_cnt, 32'd1);
      chk("fill_done_cycle", done_idx, 32'd480);
      bad = 0;
      for (int a = 0; a < 480; a++) begin
        cpu_read(9'(a), rd, rv);
        if (rd !== 32'hFFFFFFFF || rv !== 1'b1) bad++;
      end
      chk("fill_contents", bad, 32'd0);

      for (int a = 0; a < 480; a++) cpu_write(9'(a), 32'hA0000000 | 32'(a), 4'hF);
      clear_value = 8'h33;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      #1;
      chk("rst_fill_busy", {31'd0, clear_busy}, 32'd0);
      chk("rst_fill_ready", {31'd0, cpu_ready}, 32'd1);
      tick();
      rst = 1'b0;
      tick();
      bad = 0;
      for (int a = 0; a < 480; a++) begin
        cpu_read(9'(a), rd, rv);
        if (a < 100) begin
          if (rd !== 32'h33333333) bad++;
        end else begin
          if (rd !== (32'hA0000000 | 32'(a))) bad++;
        end
      end
      chk("rst_fill_contents", bad, 32'd0);
    end
`else
    clear_value = 8'h00;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("noclr_busy", {31'd0, clear_busy}, 32'd0);
    chk("noclr_ready", {31'd0, cpu_ready}, 32'd1);
    tick();
    chk("noclr_done", {31'd0, clear_done}, 32'd0);
    cpu_read(9'd0, rd, rv);
    chk("noclr_word0", rd, 32'h12345678);
    cpu_read(9'd2, rd, rv);
    chk("noclr_word2", rd, 32'h0C0B0A09);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
